// File: rtl/float64_pkg.sv
// Shared constants for the binary64 soft-float datapath: field widths, class
// encodings, unpacker FSM state codes and exception flag bits.
package float64_pkg;

    localparam int EXP_W  = 11;
    localparam int FRAC_W = 52;
    localparam int ZEXP_W = 13;
    localparam int ZSIG_W = 64;

    localparam logic [EXP_W-1:0] EXP_MAX = 11'd2047;

    localparam logic [2:0] CLS_ZERO   = 3'd0;
    localparam logic [2:0] CLS_SUBNRM = 3'd1;
    localparam logic [2:0] CLS_NORMAL = 3'd2;
    localparam logic [2:0] CLS_INF    = 3'd3;
    localparam logic [2:0] CLS_QNAN   = 3'd4;
    localparam logic [2:0] CLS_SNAN   = 3'd5;

    // One-hot; S_NORM keeps its code even in builds without the normalizer.
    localparam logic [3:0] S_IDLE   = 4'b0001;
    localparam logic [3:0] S_DECODE = 4'b0010;
    localparam logic [3:0] S_NORM   = 4'b0100;
    localparam logic [3:0] S_DONE   = 4'b1000;

    localparam logic [31:0] FLAG_INVALID = 32'h0000_0010;
    localparam logic [31:0] FLAG_INEXACT = 32'h0000_0001;

endpackage

// File: rtl/float64_classify.sv
// Combinational classifier: biased exponent and fraction fields to class code,
// plus the final zExp/zSig for every class that needs no normalization.
module float64_classify
    import float64_pkg::*;
(
    input  logic [EXP_W-1:0]  exp_field,
    input  logic [FRAC_W-1:0] frac_field,
    output logic [2:0]        cls,
    output logic [ZEXP_W-1:0] init_exp,
    output logic [ZSIG_W-1:0] init_sig
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        cls      = CLS_ZERO;
        init_exp = '0;
        init_sig = '0;
        if (exp_field == '0) begin
            // Subnormals report zeros here; the normalizer (or flush) supplies the result.
            if (frac_field != '0)
                cls = CLS_SUBNRM;
        end else if (exp_field == EXP_MAX) begin
            init_exp = {2'b00, EXP_MAX};
            init_sig = {2'b00, frac_field, 10'b0};
            if (frac_field == '0)
                cls = CLS_INF;
            else if (frac_field[FRAC_W-1])
                cls = CLS_QNAN;
            else
                cls = CLS_SNAN;
        end else begin
            cls      = CLS_NORMAL;
            init_exp = {2'b00, exp_field};
            init_sig = {1'b0, 1'b1, frac_field, 10'b0};
        end
    end

endmodule

// File: rtl/unpack_float64.sv
// Iterative IEEE-754 binary64 unpacker under ap_start/ap_done handshake.
// Define FLOAT64_SUBNORMAL_EN to normalize subnormals; otherwise they flush to zero.
module unpack_float64
    import float64_pkg::*;
(
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [63:0]       a,
    input  logic [31:0]       float_exception_flag_i,
    output logic [31:0]       float_exception_flag_o,
    output logic              float_exception_flag_o_ap_vld,
    output logic              zSign,
    output logic [ZEXP_W-1:0] zExp,
    output logic [ZSIG_W-1:0] zSig,
    output logic [2:0]        cls
);

    logic [3:0]        state;
    logic [63:0]       a_reg;
    logic [2:0]        dec_cls;
    logic [ZEXP_W-1:0] dec_exp;
    logic [ZSIG_W-1:0] dec_sig;

    float64_classify u_classify (
        .exp_field  (a_reg[62:52]),
        .frac_field (a_reg[51:0]),
        .cls        (dec_cls),
        .init_exp   (dec_exp),
        .init_sig   (dec_sig)
    );

`ifdef FLOAT64_SUBNORMAL_EN
    logic [FRAC_W:0]   sig53;
    logic [FRAC_W:0]   sig53_next;
    logic [ZEXP_W-1:0] norm_exp;
    logic [ZEXP_W-1:0] norm_exp_next;

    assign sig53_next    = {sig53[FRAC_W-1:0], 1'b0};
    assign norm_exp_next = norm_exp - 13'd1;
`endif

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            // NOTE: every register, including the captured operand, clears on reset so an aborted operand leaves no trace.
            state <= S_IDLE;
            a_reg <= '0;
            zSign <= 1'b0;
            zExp  <= '0;
            zSig  <= '0;
            cls   <= CLS_ZERO;
`ifdef FLOAT64_SUBNORMAL_EN
            sig53    <= '0;
            norm_exp <= '0;
`endif
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        a_reg <= a;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (dec_cls == CLS_SUBNRM) begin
`ifdef FLOAT64_SUBNORMAL_EN
                        sig53    <= {1'b0, a_reg[51:0]};
                        norm_exp <= 13'd1;
                        state    <= S_NORM;
`else
                        zSign <= a_reg[63];
                        zExp  <= '0;
                        zSig  <= '0;
                        cls   <= CLS_ZERO;
                        state <= S_DONE;
`endif
                    end else begin
                        zSign <= a_reg[63];
                        zExp  <= dec_exp;
                        zSig  <= dec_sig;
                        cls   <= dec_cls;
                        state <= S_DONE;
                    end
                end
`ifdef FLOAT64_SUBNORMAL_EN
                S_NORM: begin
                    sig53    <= sig53_next;
                    norm_exp <= norm_exp_next;
                    // Exit on the shift that lands the leading one in the integer position.
                    if (sig53_next[FRAC_W]) begin
                        zSign <= a_reg[63];
                        zExp  <= norm_exp_next;
                        zSig  <= {1'b0, sig53_next, 10'b0};
                        cls   <= CLS_SUBNRM;
                        state <= S_DONE;
                    end
                end
`endif
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ap_done  = (state == S_DONE);
    assign ap_ready = ap_done;
    assign ap_idle  = (state == S_IDLE) && !ap_start;

    // cls is already registered for this operand when S_DONE is entered.
    assign float_exception_flag_o_ap_vld = ap_done && (cls == CLS_SNAN);
    assign float_exception_flag_o = float_exception_flag_o_ap_vld
                                  ? (float_exception_flag_i | FLAG_INVALID)
                                  : float_exception_flag_i;

endmodule
